// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: REF_CLK-domain command engine. Decodes RX byte frames into
// register-file and ALU strobes, queues read/ALU result bytes and drains
// them to the UART TX path under a TX_BUSY handshake.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int TXQ_DEPTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     TX_BUSY,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VALID,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR
);

  localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int PW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int CW = $clog2(TXQ_DEPTH + 1);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALUN = DATA_WIDTH'(8'hDD);

  localparam logic [CW-1:0] DEPTH_C  = CW'(TXQ_DEPTH);
  localparam logic [CW-1:0] NB_ROOM  = CW'(TXQ_DEPTH - NB);
  localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_DATA, R_ADDR, R_SPACE, R_WAIT,
    A_OPA, A_OPB, A_FUN, A_SPACE, A_WAIT
  } cmd_state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_WBUSY, TX_WDONE} tx_state_t;

  cmd_state_t state, state_nxt;
  tx_state_t  tx_state, tx_state_nxt;

  logic [ADDRESS_WIDTH-1:0] tgt_addr, tgt_addr_d;
  logic [ALU_OUT_WIDTH-1:0] res, res_d;
  logic [BW-1:0]            idx, idx_d;

  logic                     wr_en_d, rd_en_d, alu_en_d, clk_en_d, cmd_err_d;
  logic [ADDRESS_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0]    wr_data_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_d;

  logic [DATA_WIDTH-1:0]    q_mem [TXQ_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            q_count;
  logic                     push, push_ok, pop;
  logic [DATA_WIDTH-1:0]    push_data;
  logic                     q_full, q_empty, room_one, room_nb;

  assign q_full   = (q_count == DEPTH_C);
  assign q_empty  = (q_count == '0);
  assign room_one = !q_full;
  assign room_nb  = (q_count <= NB_ROOM);
  assign push_ok  = push && !q_full;

  // Command FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Command FSM next-state: byte edges advance on RX_D_VLD, space/wait states on queue room or returns
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if      (RX_P_DATA == OP_WR)   state_nxt = W_ADDR;
          else if (RX_P_DATA == OP_RD)   state_nxt = R_ADDR;
          else if (RX_P_DATA == OP_ALU)  state_nxt = A_OPA;
          else if (RX_P_DATA == OP_ALUN) state_nxt = A_FUN;
        end
      end
      W_ADDR:  if (RX_D_VLD)     state_nxt = W_DATA;
      W_DATA:  if (RX_D_VLD)     state_nxt = IDLE;
      R_ADDR:  if (RX_D_VLD)     state_nxt = R_SPACE;
      R_SPACE: if (room_one)     state_nxt = R_WAIT;
      R_WAIT:  if (RdData_Valid) state_nxt = IDLE;
      A_OPA:   if (RX_D_VLD)     state_nxt = A_OPB;
      A_OPB:   if (RX_D_VLD)     state_nxt = A_FUN;
      A_FUN:   if (RX_D_VLD)     state_nxt = A_SPACE;
      A_SPACE: if (room_nb)      state_nxt = A_WAIT;
      A_WAIT: begin
        if (idx == '0) begin
          if (ALU_OUT_VALID && (NB == 1)) state_nxt = IDLE;
        end else if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command FSM outputs: next values of the registered strobes plus queue pushes
  always_comb begin
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    address_d  = Address;
    wr_data_d  = WrData;
    alu_fun_d  = ALU_FUN;
    tgt_addr_d = tgt_addr;
    res_d      = res;
    idx_d      = idx;
    push       = 1'b0;
    push_data  = '0;
    case (state)
      IDLE: begin
        if (RX_D_VLD && !(RX_P_DATA inside {OP_WR, OP_RD, OP_ALU, OP_ALUN}))
          cmd_err_d = 1'b1;
      end
      W_ADDR, R_ADDR: begin
        if (RX_D_VLD) tgt_addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
      end
      W_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = tgt_addr;
          wr_data_d = RX_P_DATA;
        end
      end
      A_OPA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = '0;
          wr_data_d = RX_P_DATA;
        end
      end
      A_OPB: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDRESS_WIDTH'(1);
          wr_data_d = RX_P_DATA;
        end
      end
      A_FUN: begin
        idx_d = '0;
        if (RX_D_VLD) alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
      end
      R_SPACE: begin
        cmd_err_d = RX_D_VLD;
        if (room_one) begin
          rd_en_d   = 1'b1;
          address_d = tgt_addr;
        end
      end
      R_WAIT: begin
        cmd_err_d = RX_D_VLD;
        if (RdData_Valid) begin
          push      = 1'b1;
          push_data = RdData;
        end
      end
      A_SPACE: begin
        cmd_err_d = RX_D_VLD;
        if (room_nb) alu_en_d = 1'b1;
      end
      A_WAIT: begin
        cmd_err_d = RX_D_VLD;
        // idx==0 waits for the result; the low byte goes straight from ALU_OUT,
        // higher bytes come from the captured copy on the following cycles.
        if (idx == '0) begin
          if (ALU_OUT_VALID) begin
            push      = 1'b1;
            push_data = ALU_OUT[DATA_WIDTH-1:0];
            res_d     = ALU_OUT;
            if (NB > 1) idx_d = BW'(1);
          end
        end else begin
          push      = 1'b1;
          push_data = DATA_WIDTH'(res >> (int'(idx) * DATA_WIDTH));
          idx_d     = (idx == LAST_IDX) ? '0 : idx + BW'(1);
        end
      end
      default: ;
    endcase
    // Gate stays open from A_SPACE entry through the cycle the result is seen
    clk_en_d = (state_nxt == A_SPACE) || ((state_nxt == A_WAIT) && (idx_d == '0));
  end

  // Registered strobes, held fields and command datapath
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      ALU_EN   <= 1'b0;
      CLK_EN   <= 1'b0;
      CMD_ERR  <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      ALU_FUN  <= '0;
      tgt_addr <= '0;
      res      <= '0;
      idx      <= '0;
    end else begin
      WrEn     <= wr_en_d;
      RdEn     <= rd_en_d;
      ALU_EN   <= alu_en_d;
      CLK_EN   <= clk_en_d;
      CMD_ERR  <= cmd_err_d;
      Address  <= address_d;
      WrData   <= wr_data_d;
      ALU_FUN  <= alu_fun_d;
      tgt_addr <= tgt_addr_d;
      res      <= res_d;
      idx      <= idx_d;
    end
  end

  // Response queue storage
  always_ff @(posedge CLK) begin
    if (push_ok) q_mem[wr_ptr] <= push_data;
  end

  // Response queue pointers and occupancy
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  // Drain FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tx_state <= TX_IDLE;
    else      tx_state <= tx_state_nxt;
  end

  // Drain FSM next-state: one byte per TX_BUSY rise/fall cycle
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (!q_empty && !TX_BUSY) tx_state_nxt = TX_WBUSY;
      TX_WBUSY: if (TX_BUSY)              tx_state_nxt = TX_WDONE;
      TX_WDONE: if (!TX_BUSY)             tx_state_nxt = TX_IDLE;
      default:                            tx_state_nxt = TX_IDLE;
    endcase
  end

  // Drain FSM outputs: present head byte and pop in the launch cycle
  always_comb begin
    TX_D_VLD  = 1'b0;
    TX_P_DATA = '0;
    pop       = 1'b0;
    if ((tx_state == TX_IDLE) && !q_empty && !TX_BUSY) begin
      TX_D_VLD  = 1'b1;
      TX_P_DATA = q_mem[rd_ptr];
      pop       = 1'b1;
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with register-file, ALU and UART TX
// responders; TX bytes are checked against a queue of expected bytes.
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        TX_BUSY;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VALID;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [3:0]  ALU_FUN;
  logic [7:0]  TX_P_DATA;

  sys_cmd_ctrl #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(4), .ALU_FUN_WIDTH(4),
    .ALU_OUT_WIDTH(16), .TXQ_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .TX_BUSY(TX_BUSY), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_cnt = 0;
  logic [3:0] last_wr_addr, last_rd_addr, last_fun;
  logic [7:0] last_wr_data;
  logic [7:0] regs [16];
  logic [7:0] exp_q [$];
  logic       tx_hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event monitor and register-file model
  always @(negedge CLK) begin
    if (WrEn === 1'b1) begin
      wr_cnt++;
      last_wr_addr = Address;
      last_wr_data = WrData;
      regs[Address] = WrData;
    end
    if (RdEn === 1'b1) begin
      rd_cnt++;
      last_rd_addr = Address;
    end
    if (ALU_EN === 1'b1) begin
      alu_cnt++;
      last_fun = ALU_FUN;
    end
    if (CMD_ERR === 1'b1) err_cnt++;
    if (TX_D_VLD === 1'b1) begin
      tx_cnt++;
      check("tx_busy_at_vld", {31'd0, TX_BUSY}, 32'd0);
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL tx_unexpected: observed byte %0h expected none", TX_P_DATA);
      end
      if (exp_q.size() > 0) check("tx_byte", {24'd0, TX_P_DATA}, {24'd0, exp_q.pop_front()});
    end
  end

  // Register read responder: 1-cycle read latency
  initial begin
    logic [3:0] a;
    RdData = '0;
    RdData_Valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (RdEn === 1'b1) begin
        a = Address;
        @(posedge CLK); #1;
        RdData = regs[a];
        RdData_Valid = 1'b1;
        @(posedge CLK); #1;
        RdData_Valid = 1'b0;
      end
    end
  end

  // ALU responder: result two cycles after ALU_EN
  initial begin
    logic [15:0] r, op_a, op_b;
    ALU_OUT = '0;
    ALU_OUT_VALID = 1'b0;
    forever begin
      @(negedge CLK);
      if (ALU_EN === 1'b1) begin
        check("clk_en_at_alu_en", {31'd0, CLK_EN}, 32'd1);
        op_a = {8'd0, regs[0]};
        op_b = {8'd0, regs[1]};
        case (ALU_FUN)
          4'd0:    r = op_a + op_b;
          4'd1:    r = op_a - op_b;
          4'd2:    r = op_a * op_b;
          default: r = op_a & op_b;
        endcase
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        ALU_OUT = r;
        ALU_OUT_VALID = 1'b1;
        @(negedge CLK);
        check("clk_en_at_valid", {31'd0, CLK_EN}, 32'd1);
        @(posedge CLK); #1;
        ALU_OUT_VALID = 1'b0;
        ALU_OUT = '0;
        @(negedge CLK);
        check("clk_en_after_valid", {31'd0, CLK_EN}, 32'd0);
      end
    end
  end

  // UART TX responder: busy for a few cycles per byte, or while tx_hold is set
  initial begin
    TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (TX_D_VLD === 1'b1) begin
        @(posedge CLK); #1;
        TX_BUSY = 1'b1;
        repeat (3) @(posedge CLK);
        while (tx_hold) @(posedge CLK);
        #1 TX_BUSY = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_read(input logic [7:0] addr);
    send_byte(8'hBB);
    send_byte(addr);
    idle(6);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
    idle(8);
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge CLK);
    check(tag, {2'd0, WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN,
                TX_P_DATA, TX_D_VLD, CMD_ERR}, 32'd0);
  endtask

  initial begin
    int wr0, rd0, alu0, err0, tx0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    RST = 1'b0;
    RX_P_DATA = '0;
    RX_D_VLD = 1'b0;
    repeat (3) @(posedge CLK);
    check_outputs_zero("reset_outputs");
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(2);

    // 1: register write, no response
    wr0 = wr_cnt; tx0 = tx_cnt;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(4);
    check("t1_wr_count", wr_cnt - wr0, 1);
    check("t1_wr_addr", {28'd0, last_wr_addr}, 32'h5);
    check("t1_wr_data", {24'd0, last_wr_data}, 32'h3C);
    check("t1_no_tx", tx_cnt - tx0, 0);
    check("t1_no_err", err_cnt, 0);

    // 2: register read returns one TX byte
    rd0 = rd_cnt; tx0 = tx_cnt;
    exp_q.push_back(8'h3C);
    do_read(8'h05);
    wait_drain(100);
    check("t2_rd_count", rd_cnt - rd0, 1);
    check("t2_rd_addr", {28'd0, last_rd_addr}, 32'h5);
    check("t2_tx_count", tx_cnt - tx0, 1);

    // 3: ALU with operands, two result bytes LSB first
    wr0 = wr_cnt; alu0 = alu_cnt; tx0 = tx_cnt;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h00);
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h03); send_byte(8'h00);
    wait_drain(200);
    check("t3_wr_count", wr_cnt - wr0, 2);
    check("t3_opa_reg0", {24'd0, regs[0]}, 32'h0A);
    check("t3_opb_addr", {28'd0, last_wr_addr}, 32'h1);
    check("t3_opb_data", {24'd0, last_wr_data}, 32'h03);
    check("t3_alu_count", alu_cnt - alu0, 1);
    check("t3_alu_fun", {28'd0, last_fun}, 32'h0);
    check("t3_tx_count", tx_cnt - tx0, 2);
    check("t3_no_err", err_cnt, 0);

    // 4: bad opcode then a normal write
    err0 = err_cnt; wr0 = wr_cnt;
    send_byte(8'h55);
    idle(3);
    check("t4_err_pulse", err_cnt - err0, 1);
    check("t4_no_wr", wr_cnt - wr0, 0);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    idle(4);
    check("t4_wr_addr", {28'd0, last_wr_addr}, 32'h1);
    check("t4_wr_data", {24'd0, last_wr_data}, 32'hFF);
    check("t4_err_total", err_cnt - err0, 1);

    // 5: TX stalled, queue filled, ALU deferred until room for two bytes
    tx_hold = 1'b1;
    tx0 = tx_cnt;
    exp_q.push_back(8'h3C);
    do_read(8'h05);
    wait_drain(100);
    exp_q.push_back(8'hFF); do_read(8'h01);
    exp_q.push_back(8'h0A); do_read(8'h00);
    exp_q.push_back(8'h3C); do_read(8'h05);
    idle(4);
    check("t5_stalled_tx", tx_cnt - tx0, 1);
    alu0 = alu_cnt; err0 = err_cnt;
    send_byte(8'hDD); send_byte(8'h02);
    idle(6);
    check("t5_alu_deferred", alu_cnt - alu0, 0);
    @(negedge CLK);
    check("t5_clk_en_in_space", {31'd0, CLK_EN}, 32'd1);
    send_byte(8'h77);
    idle(3);
    check("t5_stray_err", err_cnt - err0, 1);
    check("t5_still_deferred", alu_cnt - alu0, 0);
    exp_q.push_back(8'hF6);
    exp_q.push_back(8'h09);
    tx_hold = 1'b0;
    wait_drain(400);
    check("t5_alu_count", alu_cnt - alu0, 1);
    check("t5_alu_fun", {28'd0, last_fun}, 32'h2);
    check("t5_tx_count", tx_cnt - tx0, 6);

    // 6: reset mid-frame discards queued bytes
    tx_hold = 1'b1;
    tx0 = tx_cnt;
    exp_q.push_back(8'h3C);
    do_read(8'h05);
    wait_drain(100);
    do_read(8'h01);
    send_byte(8'hCC); send_byte(8'h0A);
    tx_hold = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_outputs_zero("t6_reset_outputs");
    @(posedge CLK); #1;
    RST = 1'b1;
    idle(12);
    check("t6_queue_discarded", tx_cnt - tx0, 1);
    rd0 = rd_cnt; err0 = err_cnt;
    exp_q.push_back(8'h0A);
    do_read(8'h00);
    wait_drain(100);
    check("t6_rd_count", rd_cnt - rd0, 1);
    check("t6_rd_addr", {28'd0, last_rd_addr}, 32'h0);
    check("t6_tx_count", tx_cnt - tx0, 2);
    check("t6_no_err", err_cnt - err0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
